conv_fw_seq: RTL and testbench
==============================

Name: conv_fw_seq

Overview:
- Sequencer for one forward pass of the conv layer.
- On a start pulse it streams a stored input image from the image BRAM into the conv block over the in_valid/in_rdy handshake.
- In parallel it captures every conv output (out_valid) into the result BRAM at the address formed from the output coordinates.
- Pulses done once the full output volume has been written; it sits between the UART load/dump logic and the conv instance.

Parameters:
- IN_DIM, 28, input image width/height in pixels.
- OUT_DIM, 12, output feature map width/height.
- OUT_CH, 8, number of output channels.
- DW, 32, data width, 16.16 fixed point.
- IN_AW, 10, image BRAM address width, laid out as {x[4:0], y[4:0]}.
- OUT_AW, 11, result BRAM address width, laid out as {idx[2:0], x[3:0], y[3:0]}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a pass; ignored unless IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the pass completes.
- err  out  1  sticky flag; cleared by an accepted start.
- img_addr  out  IN_AW  image BRAM address; read latency 1 cycle.
- img_rdata  in  DW  image BRAM read data.
- cv_in_valid  out  1  input-valid to conv.
- cv_in_rdy  in  1  conv ready for input.
- cv_in_data  out  DW  pixel to conv.
- cv_in_x, cv_in_y  out  5 each  pixel coordinates.
- cv_out_rdy  out  1  ready for conv output.
- cv_out_valid  in  1  conv output valid.
- cv_out_data  in  DW  conv output value.
- cv_out_idx  in  3  output channel.
- cv_out_x, cv_out_y  in  4 each  output coordinates.
- res_we  out  1  result BRAM write enable.
- res_addr  out  OUT_AW  result BRAM address.
- res_wdata  out  DW  result BRAM write data.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-pass abandons the pass immediately with no done pulse.
- Input FSM states: IDLE, FETCH, PRESENT, DRAIN, DONE.
  - IDLE: when start=1, clear the x/y/output counters and err, then go to FETCH.
  - FETCH: drive img_addr={x,y}; cv_in_valid=0; next cycle go to PRESENT.
  - PRESENT:
    - Register img_rdata into cv_in_data in the first PRESENT cycle and hold it stable.
    - cv_in_valid=1; cv_in_x/cv_in_y equal the current counters.
    - Transfer completes on the cycle where cv_in_valid and cv_in_rdy are both 1.
    - After a transfer: y increments. If y==IN_DIM-1, y wraps to 0 and x increments. If x==IN_DIM-1 and y==IN_DIM-1, go to DRAIN; otherwise go to FETCH.
    - A stalled cv_in_rdy holds data, coordinates and valid unchanged.
  - DRAIN: cv_in_valid=0; wait for the output count to reach OUT_CH*OUT_DIM*OUT_DIM (1152 by default), then go to DONE.
  - DONE: done=1 for one cycle, busy drops, return to IDLE.
- Pixel rate: at most one pixel per 2 cycles (FETCH + PRESENT), giving 1568 cycles minimum for 784 pixels.
- Output capture:
  - Active whenever busy, including FETCH and PRESENT; cv_out_rdy=busy.
  - On cv_out_valid && cv_out_rdy, register the write: the next cycle has res_we=1, res_addr={idx,x,y}, res_wdata=cv_out_data, so write latency is 1 cycle. The output counter increments in that same cycle.
  - Coordinates with x>=OUT_DIM or y>=OUT_DIM, or idx>=OUT_CH: no write, no count, set err.
  - cv_out_valid while IDLE: ignored (rdy=0).
- Completion is possible the same cycle the last input transfers: if the count reaches the total in PRESENT, the FSM still passes through DRAIN for one cycle before DONE.
- start while busy: ignored, no effect.
- The counter is wide enough (11 bits) for 1152 outputs, with no wrap.

Decomposition:
- Shared package conv_pkg holds:
  - state encodings (ST_IDLE..ST_DONE);
  - the default geometry constants IN_DIM/OUT_DIM/OUT_CH;
  - functions img_addr_f(x,y) and res_addr_f(idx,x,y) for address packing.
- One sub-module, conv_out_capture: output handshake, range check, registered BRAM write and output counter. The top holds the input FSM.

Test Plan:
- Reset then start with cv_in_rdy=1 and an image BRAM preloaded with addr value → 784 transfers in order (0,0),(0,1)…(0,27),(1,0)…(27,27); cv_in_data equals the address; DRAIN entered after (27,27).
- cv_in_rdy toggled 0 for 3 cycles in PRESENT at pixel (5,7) → data and coordinates held, exactly one transfer, no skip or duplicate.
- Model emits 1152 outputs (idx,x,y) with data={idx,x,y} interleaved during input streaming → every res_addr written once with matching data; done pulses exactly once, 1 cycle after DRAIN sees count 1152.
- Output with x=12 mid-pass → no res_we, err=1, done never pulses until 1152 valid outputs arrive; next start clears err.
- start pulsed at cycle 50 of an active pass → ignored, x/y counters unchanged.
- rst_n low at pixel (10,3) → all outputs 0 asynchronously; a fresh start restarts at (0,0) with count 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, default geometry and address packing for the conv forward-pass sequencer.
package conv_pkg;

  localparam int unsigned DEF_IN_DIM  = 28;
  localparam int unsigned DEF_OUT_DIM = 12;
  localparam int unsigned DEF_OUT_CH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [9:0] img_addr_f(input logic [4:0] x, input logic [4:0] y);
    return {x, y};
  endfunction

  function automatic logic [10:0] res_addr_f(input logic [2:0] idx, input logic [3:0] x,
                                             input logic [3:0] y);
    return {idx, x, y};
  endfunction

endpackage

// File: rtl/conv_out_capture.sv
// Accepts conv outputs while busy, range-checks them and issues one registered result write each.
module conv_out_capture
  import conv_pkg::*;
#(
  parameter int unsigned OUT_DIM = DEF_OUT_DIM,
  parameter int unsigned OUT_CH  = DEF_OUT_CH,
  parameter int unsigned DW      = 32,
  parameter int unsigned OUT_AW  = 11,
  parameter int unsigned CW      = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              busy_i,
  input  logic              out_valid_i,
  input  logic [DW-1:0]     out_data_i,
  input  logic [2:0]        out_idx_i,
  input  logic [3:0]        out_x_i,
  input  logic [3:0]        out_y_i,
  output logic              out_rdy_o,
  output logic              res_we_o,
  output logic [OUT_AW-1:0] res_addr_o,
  output logic [DW-1:0]     res_wdata_o,
  output logic [CW-1:0]     count_o,
  output logic              err_o
);

  logic              we_q, we_d;
  logic [OUT_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              accept;
  logic              in_range;

  assign accept   = out_valid_i && busy_i;
  assign in_range = (32'(out_x_i) < OUT_DIM) && (32'(out_y_i) < OUT_DIM) &&
                    (32'(out_idx_i) < OUT_CH);

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear_i) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (in_range) begin
        we_d    = 1'b1;
        addr_d  = OUT_AW'(res_addr_f(out_idx_i, out_x_i, out_y_i));
        wdata_d = out_data_i;
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_rdy_o   = busy_i;
  assign res_we_o    = we_q;
  assign res_addr_o  = addr_q;
  assign res_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: rtl/conv_fw_seq.sv
// Forward-pass sequencer: streams the stored image into the conv block and captures its outputs.
module conv_fw_seq
  import conv_pkg::*;
#(
  parameter int unsigned IN_DIM  = DEF_IN_DIM,
  parameter int unsigned OUT_DIM = DEF_OUT_DIM,
  parameter int unsigned OUT_CH  = DEF_OUT_CH,
  parameter int unsigned DW      = 32,
  parameter int unsigned IN_AW   = 10,
  parameter int unsigned OUT_AW  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IN_AW-1:0]  img_addr,
  input  logic [DW-1:0]     img_rdata,
  output logic              cv_in_valid,
  input  logic              cv_in_rdy,
  output logic [DW-1:0]     cv_in_data,
  output logic [4:0]        cv_in_x,
  output logic [4:0]        cv_in_y,
  output logic              cv_out_rdy,
  input  logic              cv_out_valid,
  input  logic [DW-1:0]     cv_out_data,
  input  logic [2:0]        cv_out_idx,
  input  logic [3:0]        cv_out_x,
  input  logic [3:0]        cv_out_y,
  output logic              res_we,
  output logic [OUT_AW-1:0] res_addr,
  output logic [DW-1:0]     res_wdata
);

  localparam int unsigned CntW     = 11;
  localparam int unsigned OutTotal = OUT_CH * OUT_DIM * OUT_DIM;

  state_e        state_q, state_d;
  logic [4:0]    x_q, x_d, y_q, y_d;
  logic [DW-1:0] data_q, data_d;
  logic          first_q, first_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CntW-1:0] out_count;
  logic          start_ok;
  logic          last_x, last_y;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign last_x   = (x_q == 5'(IN_DIM - 1));
  assign last_y   = (y_q == 5'(IN_DIM - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        first_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (first_q) data_d = img_rdata;
        if (cv_in_rdy) begin
          if (last_y) begin
            y_d = '0;
            if (last_x) begin
              x_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              x_d     = x_q + 5'd1;
              state_d = ST_FETCH;
            end
          end else begin
            y_d     = y_q + 5'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (out_count >= CntW'(OutTotal)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_PRESENT) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  conv_out_capture #(
    .OUT_DIM (OUT_DIM),
    .OUT_CH  (OUT_CH),
    .DW      (DW),
    .OUT_AW  (OUT_AW),
    .CW      (CntW)
  ) u_capture (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (start_ok),
    .busy_i      (busy_q),
    .out_valid_i (cv_out_valid),
    .out_data_i  (cv_out_data),
    .out_idx_i   (cv_out_idx),
    .out_x_i     (cv_out_x),
    .out_y_i     (cv_out_y),
    .out_rdy_o   (cv_out_rdy),
    .res_we_o    (res_we),
    .res_addr_o  (res_addr),
    .res_wdata_o (res_wdata),
    .count_o     (out_count),
    .err_o       (err)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign img_addr    = IN_AW'(img_addr_f(x_q, y_q));
  assign cv_in_valid = (state_q == ST_PRESENT);
  assign cv_in_x     = x_q;
  assign cv_in_y     = y_q;
  // BRAM data arrives in the first PRESENT cycle; pass it through then, hold the copy afterwards.
  assign cv_in_data  = first_q ? img_rdata : data_q;

endmodule

// File: tb/tb_conv_fw_seq.sv
// Directed bench for conv_fw_seq: image streaming, stalls, output capture, err and reset.
module tb_conv_fw_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [9:0]  img_addr;
  logic [31:0] img_rdata = '0;
  logic        cv_in_valid;
  logic        cv_in_rdy = 1'b0;
  logic [31:0] cv_in_data;
  logic [4:0]  cv_in_x, cv_in_y;
  logic        cv_out_rdy;
  logic        cv_out_valid = 1'b0;
  logic [31:0] cv_out_data = '0;
  logic [2:0]  cv_out_idx = '0;
  logic [3:0]  cv_out_x = '0;
  logic [3:0]  cv_out_y = '0;
  logic        res_we;
  logic [10:0] res_addr;
  logic [31:0] res_wdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  conv_fw_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .img_addr     (img_addr),
    .img_rdata    (img_rdata),
    .cv_in_valid  (cv_in_valid),
    .cv_in_rdy    (cv_in_rdy),
    .cv_in_data   (cv_in_data),
    .cv_in_x      (cv_in_x),
    .cv_in_y      (cv_in_y),
    .cv_out_rdy   (cv_out_rdy),
    .cv_out_valid (cv_out_valid),
    .cv_out_data  (cv_out_data),
    .cv_out_idx   (cv_out_idx),
    .cv_out_x     (cv_out_x),
    .cv_out_y     (cv_out_y),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_wdata    (res_wdata)
  );

  always #5 clk = ~clk;

  // Image BRAM preloaded with its own address, one cycle read latency.
  always @(posedge clk) img_rdata <= {22'd0, img_addr};
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] d;
    int          c;
  } xfer_t;

  xfer_t       xq[$];
  int          wr_cnt[2048];
  logic [31:0] wr_dat[2048];
  int          wr_total, last_we_cyc, done_cnt, done_cyc;

  always @(negedge clk) begin
    if (cv_in_valid && cv_in_rdy) begin
      xfer_t t;
      t.x = int'(cv_in_x);
      t.y = int'(cv_in_y);
      t.d = cv_in_data;
      t.c = cyc;
      xq.push_back(t);
    end
    if (res_we) begin
      wr_cnt[res_addr] = wr_cnt[res_addr] + 1;
      wr_dat[res_addr] = res_wdata;
      wr_total = wr_total + 1;
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    xq.delete();
    for (int i = 0; i < 2048; i++) wr_cnt[i] = 0;
    wr_total = 0;
    last_we_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    cv_out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic emit_one(input int idx, input int x, input int y, output bit ok);
    cv_out_valid = 1'b1;
    cv_out_idx   = idx[2:0];
    cv_out_x     = x[3:0];
    cv_out_y     = y[3:0];
    cv_out_data  = 32'(idx * 256 + x * 16 + y);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cv_out_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 cv_out_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic emit_all(output int fails);
    bit ok;
    fails = 0;
    for (int k = 0; k < 1152; k++) begin
      emit_one(k / 144, (k % 144) / 12, k % 12, ok);
      if (!ok) fails++;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int order_errs();
    int e = 0;
    for (int i = 0; i < xq.size(); i++) begin
      if (xq[i].x != i / 28 || xq[i].y != i % 28 || xq[i].d != 32'((i / 28) * 32 + i % 28))
        e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    total++;
    if ({busy, done, err, cv_in_valid, cv_out_rdy, res_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, err, cv_in_valid, cv_out_rdy, res_we});
    end
    total++;
    if ({img_addr, cv_in_x, cv_in_y} !== 20'd0) begin
      bad++;
      $display("FAIL reset_coords: got %h want 0", {img_addr, cv_in_x, cv_in_y});
    end
    total++;
    if ({cv_in_data, res_addr, res_wdata} !== 75'd0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {cv_in_data, res_addr, res_wdata});
    end
  endtask

  task automatic test_idle_output();
    bit rdy_seen = 1'b0;
    clear_logs();
    cv_out_valid = 1'b1;
    cv_out_idx = 3'd1;
    cv_out_x = 4'd2;
    cv_out_y = 4'd3;
    cv_out_data = 32'h123;
    repeat (4) begin
      @(posedge clk);
      #1 if (cv_out_rdy !== 1'b0) rdy_seen = 1'b1;
    end
    cv_out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rdy_seen || wr_total != 0) begin
      bad++;
      $display("FAIL idle_output: got rdy=%0d writes=%0d want 0 0", rdy_seen, wr_total);
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    bit held = 1'b1;
    int n57 = 0;
    do_reset();
    clear_logs();
    cv_in_rdy = 1'b1;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (busy && !cv_in_valid && img_addr == 10'd167) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stall_reach: got found=0 want 1");
    end
    cv_in_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (!(cv_in_valid === 1'b1 && cv_in_x == 5'd5 && cv_in_y == 5'd7 && cv_in_data == 32'd167))
        held = 1'b0;
    end
    cv_in_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    foreach (xq[i]) if (xq[i].x == 5 && xq[i].y == 7) n57++;
    total++;
    if (!held) begin
      bad++;
      $display("FAIL stall_hold: got x=%0d y=%0d d=%0d v=%0d want 5 7 167 1",
               cv_in_x, cv_in_y, cv_in_data, cv_in_valid);
    end
    total++;
    if (n57 != 1) begin
      bad++;
      $display("FAIL stall_once: got %0d transfers of (5,7) want 1", n57);
    end
    total++;
    if (order_errs() != 0 || xq.size() < 149) begin
      bad++;
      $display("FAIL stall_order: got errs=%0d size=%0d want 0 >=149", order_errs(), xq.size());
    end
  endtask

  task automatic test_start_ignored();
    int n0, d;
    do_reset();
    clear_logs();
    cv_in_rdy = 1'b1;
    pulse_start();
    repeat (48) @(posedge clk);
    #1 n0 = xq.size();
    pulse_start();
    repeat (20) @(posedge clk);
    #1 d = xq.size() - n0;
    total++;
    if (busy !== 1'b1 || order_errs() != 0 || d < 10 || d > 11) begin
      bad++;
      $display("FAIL start_ignored: got busy=%0d errs=%0d delta=%0d want 1 0 10..11",
               busy, order_errs(), d);
    end
    total++;
    if (int'(cv_in_x) != xq.size() / 28 || int'(cv_in_y) != xq.size() % 28) begin
      bad++;
      $display("FAIL start_coords: got (%0d,%0d) want (%0d,%0d)", cv_in_x, cv_in_y,
               xq.size() / 28, xq.size() % 28);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found = 1'b0;
    do_reset();
    clear_logs();
    cv_in_rdy = 1'b1;
    pulse_start();
    for (int k = 0; k < 5; k++) emit_one(0, 0, k, ok);
    for (int i = 0; i < 2000; i++) begin
      if (busy && cv_in_x == 5'd10 && cv_in_y == 5'd3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!found || {busy, done, err, cv_in_valid, cv_out_rdy, res_we} !== 6'b0) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got found=%0d ctrl=%b want 1 000000", found,
               {busy, done, err, cv_in_valid, cv_out_rdy, res_we});
    end
    total++;
    if ({img_addr, cv_in_x, cv_in_y, cv_in_data, res_addr, res_wdata} !== 95'd0) begin
      bad++;
      $display("FAIL rst_mid_data: got %h want 0",
               {img_addr, cv_in_x, cv_in_y, cv_in_data, res_addr, res_wdata});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL rst_mid_done: got %0d done pulses want 0", done_cnt);
    end
    clear_logs();
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (xq.size() < 1 || xq[0].x != 0 || xq[0].y != 0) begin
      bad++;
      $display("FAIL rst_mid_restart: got size=%0d first=(%0d,%0d) want >=1 (0,0)", xq.size(),
               xq.size() > 0 ? xq[0].x : -1, xq.size() > 0 ? xq[0].y : -1);
    end
  endtask

  task automatic check_writes(input string tag);
    int e = 0;
    for (int k = 0; k < 1152; k++) begin
      int a = (k / 144) * 256 + ((k % 144) / 12) * 16 + k % 12;
      if (wr_cnt[a] != 1 || wr_dat[a] != 32'(a)) e++;
    end
    total++;
    if (e != 0 || wr_total != 1152) begin
      bad++;
      $display("FAIL %s_writes: got errs=%0d total=%0d want 0 1152", tag, e, wr_total);
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_we_cyc + 1) begin
      bad++;
      $display("FAIL %s_done: got pulses=%0d at %0d want 1 at %0d", tag, done_cnt, done_cyc,
               last_we_cyc + 1);
    end
  endtask

  task automatic test_full_pass();
    int fails;
    do_reset();
    clear_logs();
    cv_in_rdy = 1'b1;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL full_busy: got %0d want 1", busy);
    end
    emit_all(fails);
    wait_done();
    total++;
    if (fails != 0 || xq.size() != 784 || order_errs() != 0) begin
      bad++;
      $display("FAIL full_stream: got timeouts=%0d size=%0d errs=%0d want 0 784 0", fails,
               xq.size(), order_errs());
    end
    total++;
    if (xq.size() != 784 || xq[783].c - xq[0].c != 1566) begin
      bad++;
      $display("FAIL full_rate: got span=%0d want 1566",
               xq.size() == 784 ? xq[783].c - xq[0].c : -1);
    end
    check_writes("full");
    total++;
    if ({busy, done, err} !== 3'b000) begin
      bad++;
      $display("FAIL full_end: got busy/done/err=%b want 000", {busy, done, err});
    end
  endtask

  task automatic test_bad_output();
    bit ok1, ok2;
    int fails;
    do_reset();
    clear_logs();
    cv_in_rdy = 1'b1;
    pulse_start();
    emit_one(0, 12, 0, ok1);
    emit_one(1, 3, 15, ok2);
    total++;
    if (!ok1 || !ok2 || wr_total != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL bad_coord: got writes=%0d err=%0d want 0 1", wr_total, err);
    end
    emit_all(fails);
    wait_done();
    check_writes("bad");
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL bad_sticky: got err=%0d want 1", err);
    end
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bad_clear: got err=%0d busy=%0d want 0 1", err, busy);
    end
    do_reset();
  endtask

  initial begin
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_idle_output();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_full_pass();
    test_bad_output();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
